dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//  Memory-side responder for the MA stage's load/store traffic. Accepts one word
//  request at a time over a req/ack handshake and inserts WAIT_CYC wait states.
//  Checks alignment and range, applies byte-enabled writes and returns read data.
//  It is the DM end of the MA<->DM interface for the multi-cycle MIPS variant.
// PARAMETERS
//  ADDR_W    10  word-address width; memory holds 2**ADDR_W 32-bit words
//  WAIT_CYC   2  wait states between acceptance and access (0..15)
// PORTS
//  CLK    in   1   clock, all state updates on rising edge
//  RST    in   1   reset, asynchronous, active-low
//  req    in   1   request valid from MA side
//  we     in   1   1 = store, 0 = load
//  addr   in  32   byte address; word index = addr[ADDR_W+1:2]
//  wdata  in  32   store data
//  be     in   4   store byte enables; be[i] -> wdata[8i+7:8i]
//  ack    out  1   one-cycle completion pulse (registered)
//  err    out  1   valid with ack: misaligned or out-of-range request
//  rdata  out 32   valid with ack: load data (0 on store or error)
//  busy   out  1   high whenever state != IDLE
// BEHAVIOUR
//  - Reset (RST=0, async): state=IDLE, cnt=0, ack=0, err=0, rdata=0, busy=0.
//    Memory contents are not reset.
//  - FSM states are IDLE, WAIT and RESP.
//  - IDLE: at an edge with req=1, latch we/addr/wdata/be.
//    - If addr[1:0]!=0 or addr[31:ADDR_W+2]!=0: go to RESP with err=1, rdata=0.
//      No memory access occurs. ack is high in the next cycle (latency 1).
//    - Otherwise: go to WAIT with cnt=WAIT_CYC.
//  - WAIT: at each edge with cnt!=0, cnt decrements.
//    - At the edge with cnt==0, perform the access and go to RESP.
//    - Load: rdata <= mem[idx].
//    - Store: write only the enabled bytes of mem[idx]; rdata <= 0.
//    - be=4'b0000 store completes normally and leaves memory unchanged.
//  - RESP: ack=1 (err as set) for exactly one cycle, then IDLE at the next edge.
//    ack, err and rdata return to 0 in IDLE.
//  - Latency: req sampled at edge T -> ack high in the cycle after edge
//    T+WAIT_CYC+1. WAIT_CYC=0 gives ack after edge T+1.
//  - Handshake:
//    - Requester holds req and its fields until acceptance; inputs after
//      acceptance are ignored.
//    - req during WAIT/RESP is ignored.
//    - req still high in IDLE after ack is a new request (back-to-back allowed,
//      min spacing WAIT_CYC+2 cycles).
//  - Load then store to the same word: load returns pre-store data.
//    Accesses are strictly ordered.
//  - Reset mid-transaction: abort. No write occurs if RST falls before the
//    access edge. Outputs are forced to reset values immediately.
//  - cnt width is 4 bits, and WAIT_CYC>15 is illegal.
// TESTING
//  1. WAIT_CYC=2: store addr=0x10, wdata=0xDEADBEEF, be=4'hF; then load 0x10.
//     -> each ack 3 cycles after acceptance; load rdata=0xDEADBEEF, err=0.
//  2. Byte-enable store: mem[4]=0x11223344; store 0xAABBCCDD with be=4'b0101.
//     -> load 0x10 returns 0x11BB33DD.
//  3. Misaligned load addr=0x13 and out-of-range addr=0x00001000 (ADDR_W=10).
//     -> ack after 1 cycle, err=1, rdata=0, memory unchanged.
//  4. req held high for 3 back-to-back loads of 0x0, 0x4, 0x8.
//     -> three ack pulses spaced WAIT_CYC+2 cycles apart, in order.
//     -> busy low only for one cycle between transactions.
//  5. Store accepted, RST pulsed low one cycle later (before the access edge),
//     then load of the same address.
//     -> ack/busy drop immediately; the load returns the pre-store value.
//  6. WAIT_CYC=0 rebuild: store then load.
//     -> ack after edge T+1; data correct; inputs changed after acceptance
//        have no effect.

Source files
------------

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
// Memory-side responder for the MA stage's load/store traffic in the
// multi-cycle MIPS variant. It accepts one word request at a time, inserts
// WAIT_CYC wait states, rejects misaligned or out-of-range addresses, applies
// byte-enabled stores and returns load data alongside a one-cycle ack pulse.
//
// Parameters
//   ADDR_W    word-address width; memory holds 2**ADDR_W 32-bit words
//   WAIT_CYC  wait states between acceptance and access (0..15)
//
// Ports
//   CLK    in   1   clock, rising edge
//   RST    in   1   asynchronous active-low reset
//   req    in   1   request valid from the MA side
//   we     in   1   1 = store, 0 = load
//   addr   in  32   byte address; word index = addr[ADDR_W+1:2]
//   wdata  in  32   store data
//   be     in   4   store byte enables; be[i] -> wdata[8i+7:8i]
//   ack    out  1   one-cycle completion pulse (registered)
//   err    out  1   valid with ack: misaligned or out-of-range request
//   rdata  out 32   valid with ack: load data (0 on store or error)
//   busy   out  1   high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module dm_responder #(
   parameter int ADDR_W   = 10,
   parameter int WAIT_CYC = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        ack,
   output logic        err,
   output logic [31:0] rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   // The wait counter is 4 bits wide, so WAIT_CYC must stay within 0..15.
   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);

   state_t             r_state;
   logic [3:0]         r_cnt;
   logic               r_we;
   logic [ADDR_W-1:0]  r_idx;
   logic [31:0]        r_wdata;
   logic [3:0]         r_be;
   logic               r_ack;
   logic               r_err;
   logic [31:0]        r_rdata;
   logic [31:0]        r_mem [2**ADDR_W];

   logic               w_misaligned;
   logic               w_out_of_range;
   logic               w_access;

   assign w_misaligned   = |addr[1:0];
   assign w_out_of_range = |addr[31:ADDR_W+2];
   // The single edge at which memory is touched: last wait state elapsed.
   assign w_access       = (r_state == S_WAIT) && (r_cnt == 4'd0);

   assign ack   = r_ack;
   assign err   = r_err;
   assign rdata = r_rdata;
   assign busy  = (r_state != S_IDLE);

   // NOTE: the memory array has no reset branch; clearing 2**ADDR_W words on
   // reset would forbid RAM inference, and contents are not defined at reset.
   // A reset mid-transaction still blocks the write because r_state is forced
   // to S_IDLE asynchronously, which deasserts w_access.
   always_ff @(posedge CLK) begin
      if (w_access && r_we) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
               r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

   // NOTE: every register in this block uses non-blocking assignment so that
   // all reads in a branch see the values from before the edge (e.g. the load
   // path reads r_mem and r_idx as they were, giving load-before-store order).
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_idx   <= '0;
         r_wdata <= 32'd0;
         r_be    <= 4'd0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
               r_rdata <= 32'd0;
               if (req) begin
                  r_we    <= we;
                  r_idx   <= addr[ADDR_W+1:2];
                  r_wdata <= wdata;
                  r_be    <= be;
                  if (w_misaligned || w_out_of_range) begin
                     // Rejected requests skip the wait states entirely.
                     r_state <= S_RESP;
                     r_ack   <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= LP_WAIT;
                  end
               end
            end

            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= S_RESP;
                  r_ack   <= 1'b1;
                  r_err   <= 1'b0;
                  r_rdata <= r_we ? 32'd0 : r_mem[r_idx];
               end
            end

            S_RESP: begin
               r_state <= S_IDLE;
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
               r_rdata <= 32'd0;
            end

            default: begin
               r_state <= S_IDLE;
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
               r_rdata <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
// Directed bench for dm_responder. dut0 runs with WAIT_CYC=2, dut1 with
// WAIT_CYC=0; both share clock and reset. Outputs are sampled on the falling
// edge, inputs are driven on the falling edge or just after the rising edge.
// Latency is counted in falling edges after the acceptance edge: an ack set at
// acceptance edge T+n is first seen at count n+1.
// -----------------------------------------------------------------------------
module tb_dm_responder;

   localparam int ADDR_W = 10;
   localparam int WAIT0  = 2;
   localparam int WAIT1  = 0;
   // Expected ack latencies in the counting scheme above.
   localparam int LAT0   = WAIT0 + 2;
   localparam int LAT1   = WAIT1 + 2;
   localparam int LATERR = 1;

   logic        CLK = 1'b0;
   logic        RST;

   logic        req0, we0, ack0, err0, busy0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [3:0]  be0;

   logic        req1, we1, ack1, err1, busy1;
   logic [31:0] addr1, wdata1, rdata1;
   logic [3:0]  be1;

   int          checks = 0;
   int          errors = 0;

   always #5 CLK = ~CLK;

   dm_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT0)) dut0 (
      .CLK   (CLK),
      .RST   (RST),
      .req   (req0),
      .we    (we0),
      .addr  (addr0),
      .wdata (wdata0),
      .be    (be0),
      .ack   (ack0),
      .err   (err0),
      .rdata (rdata0),
      .busy  (busy0)
   );

   dm_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT1)) dut1 (
      .CLK   (CLK),
      .RST   (RST),
      .req   (req1),
      .we    (we1),
      .addr  (addr1),
      .wdata (wdata1),
      .be    (be1),
      .ack   (ack1),
      .err   (err1),
      .rdata (rdata1),
      .busy  (busy1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int s, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b);
      if (s == 0) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d; be0 = b;
      end else begin
         req1 = r; we1 = w; addr1 = a; wdata1 = d; be1 = b;
      end
   endtask

   function automatic logic get_ack(input int s);
      return (s == 0) ? ack0 : ack1;
   endfunction

   function automatic logic get_err(input int s);
      return (s == 0) ? err0 : err1;
   endfunction

   function automatic logic get_busy(input int s);
      return (s == 0) ? busy0 : busy1;
   endfunction

   function automatic logic [31:0] get_rdata(input int s);
      return (s == 0) ? rdata0 : rdata1;
   endfunction

   // One request from an idle DUT, called at a falling edge. After acceptance
   // the fields are scrambled so that late sampling shows up as wrong data.
   // lat stays -1 if no ack arrives within the budget.
   task automatic xact(input int s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output int lat, output logic [31:0] rd, output logic e);
      lat = -1;
      rd  = 32'd0;
      e   = 1'b0;
      set_req(s, 1'b1, w, a, d, b);
      @(posedge CLK);
      #1 set_req(s, 1'b0, ~w, ~a, ~d, ~b);
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLK);
         if (get_ack(s)) begin
            lat = k;
            rd  = get_rdata(s);
            e   = get_err(s);
            break;
         end
      end
      // ack lasts exactly one cycle and the FSM is back in IDLE after it.
      @(negedge CLK);
      check("ack_single_cycle", 32'(get_ack(s)), 32'd0);
      check("idle_after_resp", 32'(get_busy(s)), 32'd0);
   endtask

   // Watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        e;
      logic [31:0] b2b_addr [3];
      logic [31:0] b2b_data [3];
      int          ack_cyc [3];
      int          n;
      int          busy_low;

      RST = 1'b0;
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (2) @(negedge CLK);

      // Reset state.
      check("rst_ack", 32'(ack0), 32'd0);
      check("rst_err", 32'(err0), 32'd0);
      check("rst_rdata", rdata0, 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_busy1", 32'(busy1), 32'd0);
      RST = 1'b1;
      @(negedge CLK);

      // Full-word store then load, WAIT_CYC=2.
      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, e);
      check("st_lat", 32'(lat), 32'(LAT0));
      check("st_rdata", rd, 32'd0);
      check("st_err", 32'(e), 32'd0);
      xact(0, 1'b0, 32'h10, 32'd0, 4'h0, lat, rd, e);
      check("ld_lat", 32'(lat), 32'(LAT0));
      check("ld_rdata", rd, 32'hDEADBEEF);
      check("ld_err", 32'(e), 32'd0);

      // Byte-enabled store over 0x11223344 with be=0101.
      xact(0, 1'b1, 32'h10, 32'h11223344, 4'hF, lat, rd, e);
      xact(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, lat, rd, e);
      xact(0, 1'b0, 32'h10, 32'd0, 4'h0, lat, rd, e);
      check("be_merge", rd, 32'h11BB33DD);
      // be=0000 store completes normally and changes nothing.
      xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, e);
      check("be0_lat", 32'(lat), 32'(LAT0));
      check("be0_err", 32'(e), 32'd0);
      xact(0, 1'b0, 32'h10, 32'd0, 4'h0, lat, rd, e);
      check("be0_unchanged", rd, 32'h11BB33DD);

      // Misaligned and out-of-range requests.
      xact(0, 1'b0, 32'h13, 32'd0, 4'h0, lat, rd, e);
      check("mis_lat", 32'(lat), 32'(LATERR));
      check("mis_err", 32'(e), 32'd1);
      check("mis_rdata", rd, 32'd0);
      xact(0, 1'b0, 32'h00001000, 32'd0, 4'h0, lat, rd, e);
      check("oor_lat", 32'(lat), 32'(LATERR));
      check("oor_err", 32'(e), 32'd1);
      check("oor_rdata", rd, 32'd0);
      xact(0, 1'b1, 32'h12, 32'h0, 4'hF, lat, rd, e);
      check("mis_st_err", 32'(e), 32'd1);
      // 0x1010 would alias word 4 if the high bits were dropped.
      xact(0, 1'b1, 32'h00001010, 32'h0, 4'hF, lat, rd, e);
      check("oor_st_err", 32'(e), 32'd1);
      xact(0, 1'b0, 32'h10, 32'd0, 4'h0, lat, rd, e);
      check("err_no_write", rd, 32'h11BB33DD);

      // Reset during the ack cycle drops ack/err/busy immediately.
      set_req(0, 1'b1, 1'b0, 32'h13, 32'd0, 4'h0);
      @(posedge CLK);
      #1 set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      @(negedge CLK);
      check("pre_rst_ack", 32'(ack0), 32'd1);
      RST = 1'b0;
      #1;
      check("rst_resp_ack", 32'(ack0), 32'd0);
      check("rst_resp_err", 32'(err0), 32'd0);
      check("rst_resp_busy", 32'(busy0), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      // Back-to-back loads with req held high.
      b2b_addr[0] = 32'h0; b2b_data[0] = 32'h01010101;
      b2b_addr[1] = 32'h4; b2b_data[1] = 32'h02020202;
      b2b_addr[2] = 32'h8; b2b_data[2] = 32'h03030303;
      for (int i = 0; i < 3; i++) begin
         xact(0, 1'b1, b2b_addr[i], b2b_data[i], 4'hF, lat, rd, e);
      end
      n        = 0;
      busy_low = 0;
      ack_cyc  = '{default: 0};
      set_req(0, 1'b1, 1'b0, b2b_addr[0], 32'd0, 4'h0);
      for (int c = 1; c <= 60 && n < 3; c++) begin
         @(negedge CLK);
         if (!busy0 && n > 0) busy_low++;
         if (ack0) begin
            ack_cyc[n] = c;
            check("b2b_rdata", rdata0, b2b_data[n]);
            check("b2b_err", 32'(err0), 32'd0);
            n++;
            // Present the next request now; it is accepted after IDLE is reached.
            if (n < 3) set_req(0, 1'b1, 1'b0, b2b_addr[n], 32'd0, 4'h0);
            else       set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
         end
      end
      check("b2b_count", 32'(n), 32'd3);
      // Pulse period: RESP, one IDLE cycle, then WAIT_CYC+1 cycles in WAIT,
      // i.e. WAIT_CYC+2 quiet cycles between consecutive ack pulses.
      check("b2b_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'(WAIT0 + 3));
      check("b2b_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'(WAIT0 + 3));
      check("b2b_busy_low", 32'(busy_low), 32'd2);
      @(negedge CLK);
      @(negedge CLK);

      // Store aborted by reset before its access edge.
      xact(0, 1'b1, 32'h20, 32'h5555AAAA, 4'hF, lat, rd, e);
      set_req(0, 1'b1, 1'b1, 32'h20, 32'hFFFF0000, 4'hF);
      @(posedge CLK);
      #1 set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      @(negedge CLK);
      check("abort_busy_before", 32'(busy0), 32'd1);
      RST = 1'b0;
      #1;
      check("abort_busy", 32'(busy0), 32'd0);
      check("abort_ack", 32'(ack0), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      xact(0, 1'b0, 32'h20, 32'd0, 4'h0, lat, rd, e);
      check("abort_no_write", rd, 32'h5555AAAA);

      // WAIT_CYC=0 instance: store then load, inputs scrambled after acceptance.
      xact(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, lat, rd, e);
      check("w0_st_lat", 32'(lat), 32'(LAT1));
      check("w0_st_rdata", rd, 32'd0);
      xact(1, 1'b0, 32'h40, 32'd0, 4'h0, lat, rd, e);
      check("w0_ld_lat", 32'(lat), 32'(LAT1));
      check("w0_ld_rdata", rd, 32'hCAFEF00D);
      check("w0_ld_err", 32'(e), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
